// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide path: operand width, divider
// iteration count and the control state encoding.
package muldiv_pkg;

    localparam int MULDIV_WIDTH   = 32;
    localparam int DIV_ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Handshake/result bundle between the control unit (master) and the divider (slave).
interface div_seq_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);

    logic             iniciar;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             flag;
    logic             div_zero;

    modport master (
        output iniciar, a, b,
        input  hi, lo, flag, div_zero
    );

    modport slave (
        input  iniciar, a, b,
        output hi, lo, flag, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes:
// shift {rem, quo} left, try subtracting the divisor, keep it if non-negative.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [2*WIDTH:0] pair_sh;
    logic [WIDTH:0]   trial;

    // rem stays below divisor (<= 2^(WIDTH-1)), so the shifted value fits and
    // the top bit of the 33-bit trial is a reliable sign.
    always_comb begin
        pair_sh = {rem, quo} << 1;
        trial   = pair_sh[2*WIDTH:WIDTH] - divisor;
        if (!trial[WIDTH]) begin
            rem_nxt = trial;
            quo_nxt = {pair_sh[WIDTH-1:1], 1'b1};
        end else begin
            rem_nxt = pair_sh[2*WIDTH:WIDTH];
            quo_nxt = pair_sh[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS div): quotient to lo, remainder to hi,
// one quotient bit per clock on magnitudes, signs applied in a final cycle.
module div_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic      clock,
    input  logic      reset,
    div_seq_if.slave  bus
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERATIONS - 1);

    muldiv_state_e    state;
    logic [5:0]       cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   divisor;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // |-2^(WIDTH-1)| wraps to the same bit pattern, which is correct read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
        return neg ? -m : m;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.flag     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else if (bus.iniciar) begin
            // A start aborts whatever is in flight; hi/lo keep the last result.
            cnt          <= '0;
            rem          <= '0;
            quo          <= magnitude(bus.a);
            divisor      <= {1'b0, magnitude(bus.b)};
            sign_q       <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_r       <= bus.a[WIDTH-1];
            if (bus.b == '0) begin
                state        <= DONE;
                bus.flag     <= 1'b1;
                bus.div_zero <= 1'b1;
            end else begin
                state        <= RUN;
                bus.flag     <= 1'b0;
                bus.div_zero <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_ITER) state <= FIX;
                end
                FIX: begin
                    bus.lo   <= apply_sign(quo, sign_q);
                    bus.hi   <= apply_sign(rem[WIDTH-1:0], sign_r);
                    bus.flag <= 1'b1;
                    state    <= DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divisions with hand-computed results.
module tb_div_seq;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] dz;
        logic [31:0] lat;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    bit   armed = 1'b0;
    int   cyc   = 0;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Track cycles since the last accepted start; reset cancels tracking.
    always @(posedge clock) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (bus.iniciar) begin
            armed <= 1'b1;
            cyc   <= 0;
        end else if (armed) begin
            cyc <= cyc + 1;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            if (bus.flag) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got lo=%h hi=%h expected none", bus.lo, bus.hi);
                end else begin
                    cur = sb.pop_front();
                    check("lo", bus.lo, cur.lo);
                    check("hi", bus.hi, cur.hi);
                    check("div_zero", {31'd0, bus.div_zero}, cur.dz);
                    check("latency", cyc, cur.lat);
                end
                armed <= 1'b0;
            end else if (cyc > 40) begin
                total++;
                bad++;
                $display("FAIL result_timeout: got no flag after %0d cycles expected <= 33", cyc);
                armed <= 1'b0;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic run(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] hi_e, input logic [31:0] lo_e, input logic dz_e);
        exp_t e;
        e.hi  = hi_e;
        e.lo  = lo_e;
        e.dz  = {31'd0, dz_e};
        e.lat = dz_e ? 32'd0 : 32'd33;
        sb.push_back(e);
        bus.iniciar = 1'b1;
        bus.a       = av;
        bus.b       = bv;
        @(negedge clock);
        bus.iniciar = 1'b0;
        wait_done();
    endtask

    initial begin
        exp_t e;
        int   fh;
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        repeat (3) @(negedge clock);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_flag", {31'd0, bus.flag}, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run(32'd100,        32'd7,          32'd2,          32'd14,         1'b0);
        run(32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0);
        run(32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0);
        run(32'd5,          32'd0,          32'd1,          32'hFFFFFFFD,   1'b1);
        run(32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0);
        run(32'd0,          32'd9,          32'd0,          32'd0,          1'b0);

        // Restart at E10: only 50/5 may ever be reported.
        e.hi  = 32'd0;
        e.lo  = 32'd10;
        e.dz  = 32'd0;
        e.lat = 32'd33;
        sb.push_back(e);
        bus.iniciar = 1'b1;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        @(negedge clock);
        bus.iniciar = 1'b0;
        repeat (9) @(negedge clock);
        bus.iniciar = 1'b1;
        bus.a       = 32'd50;
        bus.b       = 32'd5;
        @(negedge clock);
        bus.iniciar = 1'b0;
        wait_done();

        // Reset at E15 of a 100/7 run.
        bus.iniciar = 1'b1;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        @(negedge clock);
        bus.iniciar = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_flag", {31'd0, bus.flag}, 32'd0);
        check("midrst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        fh = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.flag) fh++;
        end
        check("no_flag_after_reset", fh, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
